fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 64'h0000_0000_8000_0000, is the address of the first fetch after reset.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 redirect_i  input  1  pulse: the next fetch address is dnpc_i (branch/jump/trap).
REQ-005 dnpc_i  input  64  redirect target, sampled when redirect_i=1.
REQ-006 imem_req_o  output  1  instruction-memory request valid.
REQ-007 imem_addr_o  output  64  fetch address for the request.
REQ-008 imem_gnt_i  input  1  memory accepts the request this cycle.
REQ-009 imem_rvalid_i  input  1  read data valid, at least 1 cycle after gnt.
REQ-010 imem_rdata_i  input  32  fetched instruction word.
REQ-011 inst_valid_o  output  1  instruction presented to decode.
REQ-012 inst_o  output  32  held instruction.
REQ-013 pc_o  output  64  address of inst_o.
REQ-014 inst_ready_i  input  1  decode accepts inst_o this cycle.
REQ-015 fetch_cnt_o  output  32  count of instructions accepted by decode, wraps modulo 2^32.

Function
REQ-016 The FSM SHALL have the states IDLE, REQ, WAIT and HOLD, and SHALL enter IDLE on reset.
REQ-017 IDLE SHALL go to REQ unconditionally on the next edge, giving a first request 1 cycle after rst deasserts.
- REQ-018 REQ:
  - imem_req_o=1 and imem_addr_o=pc_q.
  - gnt moves to WAIT.
  - Without gnt, addr and req SHALL stay stable.
- REQ-019 WAIT:
  - imem_req_o=0.
  - rvalid captures rdata into inst_o and pc_q into pc_o, then moves to HOLD.
  - If drop_q=1, rvalid instead discards the data, clears drop_q and moves to REQ.
- REQ-020 HOLD:
  - inst_valid_o=1.
  - inst_o and pc_o SHALL stay stable while inst_ready_i=0.
  - inst_ready_i=1 sets pc_q<=pc_q+4, increments fetch_cnt_o and moves to REQ.
REQ-021 A redirect SHALL always load pc_q<=dnpc_i with bits [1:0] forced to 0.
- REQ-022 Redirect handling by state:
  - In REQ without gnt: stay in REQ, so the next request uses the new address.
  - In REQ with gnt, or in WAIT: set drop_q.
  - In HOLD: deassert inst_valid_o next cycle and move to REQ.
REQ-023 Redirect and inst_ready_i in the same HOLD cycle SHALL count the handshake (fetch_cnt_o+1), and the redirect target SHALL win over pc_q+4.
REQ-024 Redirect and rvalid in the same WAIT cycle SHALL discard the data and move to REQ with pc_q=dnpc_i.
REQ-025 pc_q+4 SHALL wrap modulo 2^64.
REQ-026 An imem_rvalid_i outside WAIT SHALL be ignored.
REQ-027 At most one request SHALL be outstanding, giving a throughput of one instruction per 3 cycles with zero-wait memory and ready decode.
REQ-028 inst_valid_o SHALL be a registered state decode, not combinational from any input.

Reset
REQ-029 While rst=1 the outputs SHALL be: state IDLE, pc_q=RESET_PC, drop_q=0, imem_req_o=0, imem_addr_o=RESET_PC, inst_valid_o=0, inst_o=0, pc_o=0, fetch_cnt_o=0.
REQ-030 A reset asserted mid-transaction SHALL abandon it immediately, and a late rvalid SHALL not be delivered.

Structure
REQ-031 The data widths (64/32), RESET_PC and the 2-bit state encoding SHALL live in the shared define file.
REQ-032 A single sub-module fetch_pc_reg SHALL hold pc_q, applying redirect priority over +4, with async reset to RESET_PC.

Verification
REQ-033 Reset release, gnt=1, rvalid one cycle later with 0x00000013, ready=1 -> req@addr 0x80000000, valid 2 cycles later, next req@0x80000004, fetch_cnt_o=1.
REQ-034 gnt held low 5 cycles -> imem_req_o=1 and imem_addr_o stable at 0x80000000 all 5 cycles.
REQ-035 Redirect to 0x80000103 during WAIT -> returned data discarded, inst_valid_o stays 0, next req@0x80000100.
REQ-036 HOLD with ready=0 for 4 cycles, then redirect plus ready together -> inst_o stable the 4 cycles, fetch_cnt_o+1, next req@dnpc.
REQ-037 pc_q=0xFFFFFFFFFFFFFFFC accepted -> next req@0x0.
REQ-038 rst asserted in WAIT, then rvalid -> all outputs at reset values, no valid, first req@RESET_PC.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared widths, reset PC and FSM encoding for the fetch unit.
// Imported by fetch_ctrl and fetch_pc_reg.
package fetch_ctrl_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEF =
    64'h0000_0000_8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_e;

  function automatic logic [XLEN-1:0] align4(
    input logic [XLEN-1:0] a
  );
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_ctrl_pc_reg.sv
// Fetch PC register: redirect (word aligned) beats +4, reset to RESET_PC.
// Ports: clk, rst, redirect_i, dnpc_i, adv_i (step +4), pc_o (pc_q).
module fetch_pc_reg
  import fetch_ctrl_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] dnpc_i,
  input  logic            adv_i,
  output logic [XLEN-1:0] pc_o
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_o <= RESET_PC;
    end else if (redirect_i) begin
      pc_o <= align4(dnpc_i);
    end else if (adv_i) begin
      pc_o <= pc_o + XLEN'(4);
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding imem request, holds the
// word for decode. Ports: clk/rst, redirect_i/dnpc_i, imem_* bus,
// inst_valid_o/inst_o/pc_o/inst_ready_i to decode, fetch_cnt_o.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] dnpc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [ILEN-1:0] imem_rdata_i,
  output logic            inst_valid_o,
  output logic [ILEN-1:0] inst_o,
  output logic [XLEN-1:0] pc_o,
  input  logic            inst_ready_i,
  output logic [31:0]     fetch_cnt_o
);

  fetch_state_e    state_q, state_d;
  logic            drop_q, drop_d;
  logic            adv, cap, cnt_inc;
  logic [XLEN-1:0] pc_q;
  logic [ILEN-1:0] inst_q;
  logic [XLEN-1:0] pc_out_q;
  logic [31:0]     cnt_q;

  fetch_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk        (clk),
    .rst        (rst),
    .redirect_i (redirect_i),
    .dnpc_i     (dnpc_i),
    .adv_i      (adv),
    .pc_o       (pc_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      drop_q   <= 1'b0;
      inst_q   <= '0;
      pc_out_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      if (cap) begin
        inst_q   <= imem_rdata_i;
        pc_out_q <= pc_q;
      end
      if (cnt_inc) begin
        cnt_q <= cnt_q + 32'd1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    drop_d       = drop_q;
    adv          = 1'b0;
    cap          = 1'b0;
    cnt_inc      = 1'b0;
    imem_req_o   = 1'b0;
    inst_valid_o = 1'b0;
    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        imem_req_o = 1'b1;
        if (imem_gnt_i) begin
          state_d = WAIT;
          // in-flight word now belongs to the old path
          if (redirect_i) drop_d = 1'b1;
        end
      end
      WAIT: begin
        if (imem_rvalid_i) begin
          if (drop_q || redirect_i) begin
            state_d = REQ;
            drop_d  = 1'b0;
          end else begin
            state_d = HOLD;
            cap     = 1'b1;
          end
        end else if (redirect_i) begin
          drop_d = 1'b1;
        end
      end
      HOLD: begin
        inst_valid_o = 1'b1;
        if (inst_ready_i) begin
          adv     = 1'b1;
          cnt_inc = 1'b1;
          state_d = REQ;
        end else if (redirect_i) begin
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign imem_addr_o = pc_q;
  assign inst_o      = inst_q;
  assign pc_o        = pc_out_q;
  assign fetch_cnt_o = cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Table-driven bench for fetch_ctrl with a scoreboard queue of
// expected post-edge outputs, plus a reset-abort sequence.
module tb_fetch_ctrl;

  localparam logic [63:0] R = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_i = 1'b0;
  logic [63:0] dnpc_i = '0;
  logic        imem_req_o;
  logic [63:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [63:0] pc_o;
  logic        inst_ready_i = 1'b0;
  logic [31:0] fetch_cnt_o;

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .redirect_i    (redirect_i),
    .dnpc_i        (dnpc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .inst_valid_o  (inst_valid_o),
    .inst_o        (inst_o),
    .pc_o          (pc_o),
    .inst_ready_i  (inst_ready_i),
    .fetch_cnt_o   (fetch_cnt_o)
  );

  typedef struct {
    string       name;
    logic        rd;
    logic [63:0] dn;
    logic        g;
    logic        rv;
    logic [31:0] dat;
    logic        rdy;
    logic        e_req;
    logic [63:0] e_addr;
    logic        e_val;
    logic [31:0] e_inst;
    logic [63:0] e_pc;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t mk(
    string nm, logic rd, logic [63:0] dn, logic g, logic rv,
    logic [31:0] dat, logic rdy, logic eq, logic [63:0] ea,
    logic ev, logic [31:0] ei, logic [63:0] ep, logic [31:0] ec
  );
    vec_t v;
    v.name = nm; v.rd = rd; v.dn = dn; v.g = g; v.rv = rv;
    v.dat = dat; v.rdy = rdy; v.e_req = eq; v.e_addr = ea;
    v.e_val = ev; v.e_inst = ei; v.e_pc = ep; v.e_cnt = ec;
    return v;
  endfunction

  task automatic compare();
    vec_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard: got empty queue, want an entry");
      return;
    end
    e = sb.pop_front();
    n_cmp++;
    if (imem_req_o !== e.e_req || imem_addr_o !== e.e_addr ||
        inst_valid_o !== e.e_val || inst_o !== e.e_inst ||
        pc_o !== e.e_pc || fetch_cnt_o !== e.e_cnt) begin
      n_bad++;
      $display({"FAIL %s: got req=%b addr=%h val=%b inst=%h pc=%h",
                " cnt=%0d / want req=%b addr=%h val=%b inst=%h",
                " pc=%h cnt=%0d"},
               e.name, imem_req_o, imem_addr_o, inst_valid_o,
               inst_o, pc_o, fetch_cnt_o, e.e_req, e.e_addr,
               e.e_val, e.e_inst, e.e_pc, e.e_cnt);
    end
  endtask

  task automatic drive(input vec_t v);
    redirect_i    = v.rd;
    dnpc_i        = v.dn;
    imem_gnt_i    = v.g;
    imem_rvalid_i = v.rv;
    imem_rdata_i  = v.dat;
    inst_ready_i  = v.rdy;
  endtask

  task automatic step(input vec_t v);
    drive(v);
    sb.push_back(v);
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic check_now(input vec_t v);
    sb.push_back(v);
    compare();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] a1, w;
    a1 = 64'h8000_0100;
    w  = 64'hFFFF_FFFF_FFFF_FFFC;

    tbl.push_back(mk("idle2req", 0,0,0,0,0,0, 1,R,0,0,0,0));
    for (int k = 0; k < 5; k++)
      tbl.push_back(mk("gnt_low", 0,0,0,(k==2),32'hdead_beef,0,
                       1,R,0,0,0,0));
    tbl.push_back(mk("gnt1", 0,0,1,0,0,0, 0,R,0,0,0,0));
    tbl.push_back(mk("rvalid1", 0,0,0,1,32'h13,0,
                     0,R,1,32'h13,R,0));
    tbl.push_back(mk("accept1", 0,0,0,0,0,1,
                     1,R+64'd4,0,32'h13,R,1));
    tbl.push_back(mk("gnt2", 0,0,1,0,0,0,
                     0,R+64'd4,0,32'h13,R,1));
    tbl.push_back(mk("redir_wait", 1,64'h8000_0103,0,0,0,0,
                     0,a1,0,32'h13,R,1));
    tbl.push_back(mk("drop_data", 0,0,0,1,32'h0bad,0,
                     1,a1,0,32'h13,R,1));
    tbl.push_back(mk("gnt3", 0,0,1,0,0,0, 0,a1,0,32'h13,R,1));
    tbl.push_back(mk("rvalid3", 0,0,0,1,32'h0010_0093,0,
                     0,a1,1,32'h0010_0093,a1,1));
    for (int k = 0; k < 4; k++)
      tbl.push_back(mk("hold_stall", 0,0,(k==3),(k==1),
                       32'hffff_ffff,0,
                       0,a1,1,32'h0010_0093,a1,1));
    tbl.push_back(mk("redir_accept", 1,64'hFFFF_FFFF_FFFF_FFFD,
                     0,0,0,1, 1,w,0,32'h0010_0093,a1,2));
    tbl.push_back(mk("gnt4", 0,0,1,0,0,0,
                     0,w,0,32'h0010_0093,a1,2));
    tbl.push_back(mk("rvalid4", 0,0,0,1,32'h73,0,
                     0,w,1,32'h73,w,2));
    tbl.push_back(mk("pc_wrap", 0,0,0,0,0,1,
                     1,64'h0,0,32'h73,w,3));
    tbl.push_back(mk("redir_req", 1,64'h1234_5678_9abc_def1,
                     0,0,0,0,
                     1,64'h1234_5678_9abc_def0,0,32'h73,w,3));
    tbl.push_back(mk("gnt_redir", 1,64'h40,1,0,0,0,
                     0,64'h40,0,32'h73,w,3));
    tbl.push_back(mk("drop2", 0,0,0,1,32'h1,0,
                     1,64'h40,0,32'h73,w,3));
    tbl.push_back(mk("gnt5", 0,0,1,0,0,0,
                     0,64'h40,0,32'h73,w,3));
    tbl.push_back(mk("redir_rvalid", 1,64'h200,0,1,32'h2,0,
                     1,64'h200,0,32'h73,w,3));
    tbl.push_back(mk("gnt6", 0,0,1,0,0,0,
                     0,64'h200,0,32'h73,w,3));
    tbl.push_back(mk("rvalid6", 0,0,0,1,32'h11,0,
                     0,64'h200,1,32'h11,64'h200,3));
    tbl.push_back(mk("redir_hold", 1,64'h300,0,0,0,0,
                     1,64'h300,0,32'h11,64'h200,3));
    tbl.push_back(mk("gnt7", 0,0,1,0,0,0,
                     0,64'h300,0,32'h11,64'h200,3));

    repeat (2) @(posedge clk);
    #1;
    check_now(mk("reset_vals", 0,0,0,0,0,0, 0,R,0,0,0,0));
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i]);

    // reset while a request is outstanding in WAIT
    #2;
    rst = 1'b1;
    drive(mk("x", 0,0,0,1,32'hdead,0, 0,0,0,0,0,0));
    #1;
    check_now(mk("rst_async", 0,0,0,0,0,0, 0,R,0,0,0,0));
    @(posedge clk);
    #1;
    check_now(mk("rst_held", 0,0,0,0,0,0, 0,R,0,0,0,0));
    rst = 1'b0;
    step(mk("rst_late_rv", 0,0,0,1,32'hdead,0, 1,R,0,0,0,0));
    step(mk("rst_rv_ign", 0,0,0,1,32'hdead,0, 1,R,0,0,0,0));
    step(mk("rst_gnt", 0,0,1,0,0,0, 0,R,0,0,0,0));
    step(mk("rst_rvalid", 0,0,0,1,32'h55,0, 0,R,1,32'h55,R,0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
